// File: rtl/mux4to1_pkg.sv
// Shared select encoding and defaults for the mux4to1 registered 4:1 selector.
package mux4to1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_X0 = 2'b00;
  localparam sel_t SEL_X1 = 2'b01;
  localparam sel_t SEL_X2 = 2'b10;
  localparam sel_t SEL_X3 = 2'b11;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux4to1_sel.sv
// Purely combinational 4:1 selector; every select code maps to one data input.
module mux4to1_sel
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    unique case (sel)
      SEL_X0: y = x0;
      SEL_X1: y = x1;
      SEL_X2: y = x2;
      SEL_X3: y = x3;
    endcase
  end

endmodule

// File: rtl/mux4to1.sv
// Registered 4:1 selector with select-change pulse.
// Define MUX4TO1_COMB_OUT_EN to drive y combinationally (sel_chg stays registered).
module mux4to1
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic             c0,
  input  logic             c1,
  output logic [WIDTH-1:0] y,
  output logic             sel_chg
);

  sel_t             sel;
  logic [WIDTH-1:0] sel_data;

  assign sel = {c1, c0};

  mux4to1_sel #(.WIDTH(WIDTH)) u_sel (
    .sel (sel),
    .x0  (x0),
    .x1  (x1),
    .x2  (x2),
    .x3  (x3),
    .y   (sel_data)
  );

  sel_t sel_q, sel_d;
  logic sel_chg_q, sel_chg_d;

  // A disabled edge holds the select and never reports a change.
  always_comb begin
    sel_d     = sel_q;
    sel_chg_d = 1'b0;
    if (en) begin
      sel_d     = sel;
      sel_chg_d = (sel != sel_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SEL_X0;
      sel_chg_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign sel_chg = sel_chg_q;

`ifdef MUX4TO1_COMB_OUT_EN
  assign y = sel_data;
`else
  logic [WIDTH-1:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (en) y_d = sel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y_d;
  end

  assign y = y_q;
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Self-checking bench for mux4to1: random and directed stimulus against a behavioural model.
module tb_mux4to1;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         c0 = 1'b0;
  logic         c1 = 1'b0;
  logic [W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic [W-1:0] y;
  logic         sel_chg;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state: last captured data, last captured select, pulse.
  logic [W-1:0] m_y = '0;
  int           m_sel = 0;
  logic         m_chg = 1'b0;

  always #5 clk = ~clk;

  mux4to1 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .c0      (c0),
    .c1      (c1),
    .y       (y),
    .sel_chg (sel_chg)
  );

  function automatic logic [W-1:0] cur_x(input int s);
    logic [W-1:0] xa [4];
    xa = '{x0, x1, x2, x3};
    return xa[s];
  endfunction

  function automatic logic [W-1:0] exp_y();
`ifdef MUX4TO1_COMB_OUT_EN
    return cur_x(int'({c1, c0}));
`else
    return m_y;
`endif
  endfunction

  task automatic model_reset();
    m_y   = '0;
    m_sel = 0;
    m_chg = 1'b0;
  endtask

  task automatic apply_edge(input logic e, input int s,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] cc, input logic [W-1:0] d);
    logic [1:0] sv;
    sv = s[1:0];
    en = e;
    {c1, c0} = sv;
    x0 = a; x1 = b; x2 = cc; x3 = d;
    @(posedge clk);
    if (rst_n) begin
      if (e) begin
        m_chg = (s != m_sel);
        m_y   = cur_x(s);
        m_sel = s;
      end else begin
        m_chg = 1'b0;
      end
    end
    #1;
    $display("txn t=%0t en=%0b sel=%0d x=%h,%h,%h,%h y=%h sel_chg=%0b",
             $time, e, s, a, b, cc, d, y, sel_chg);
  endtask

  task automatic test_reset();
    x0 = '1; x1 = '1; x2 = '1; x3 = '1;
    {c1, c0} = 2'b11;
    en = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (y !== exp_y() || sel_chg !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold y=%h sel_chg=%0b want y=%h sel_chg=0", y, sel_chg, exp_y());
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_edge(1'b1, 3, '1, '1, '1, '1);
    n_vec++;
    if (y !== {W{1'b1}} || sel_chg !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release y=%h sel_chg=%0b want y=%h sel_chg=1", y, sel_chg, {W{1'b1}});
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] p;
    for (int pi = 0; pi < 16; pi++) begin
      for (int s = 0; s < 4; s++) begin
        p = pi[3:0];
        apply_edge(1'b1, s, W'(p[0]), W'(p[1]), W'(p[2]), W'(p[3]));
        n_vec++;
        if (y !== exp_y() || y !== W'(p[s]) || sel_chg !== m_chg) begin
          n_bad++;
          $display("FAIL exhaustive p=%b sel=%0d y=%h sel_chg=%0b want y=%h sel_chg=%0b",
                   p, s, y, sel_chg, W'(p[s]), m_chg);
        end
      end
    end
  endtask

  task automatic test_sel_change();
    apply_edge(1'b1, 0, '0, '0, '1, '0);
    apply_edge(1'b1, 2, '0, '0, '1, '0);
    n_vec++;
    if (sel_chg !== 1'b1 || y !== exp_y()) begin
      n_bad++;
      $display("FAIL sel_chg_rise sel_chg=%0b y=%h want sel_chg=1 y=%h", sel_chg, y, exp_y());
    end
    for (int k = 0; k < 2; k++) begin
      apply_edge(1'b1, 2, '0, '0, '1, '0);
      n_vec++;
      if (sel_chg !== 1'b0) begin
        n_bad++;
        $display("FAIL sel_chg_hold k=%0d sel_chg=%0b want 0", k, sel_chg);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [W-1:0] held;
    apply_edge(1'b1, 0, '1, '0, '0, '0);
    held = y;
    apply_edge(1'b0, 3, '0, '0, '0, '0);
    n_vec++;
    if (y !== exp_y() || sel_chg !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_hold y=%h sel_chg=%0b want y=%h sel_chg=0 (held %h)",
               y, sel_chg, exp_y(), held);
    end
    apply_edge(1'b1, 3, '0, '0, '0, '0);
    n_vec++;
    if (y !== '0 || sel_chg !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_resume y=%h sel_chg=%0b want y=0 sel_chg=1", y, sel_chg);
    end
  endtask

  task automatic test_async_reset();
    apply_edge(1'b1, 1, '0, '1, '0, '0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (y !== exp_y() || sel_chg !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset y=%h sel_chg=%0b want y=%h sel_chg=0", y, sel_chg, exp_y());
    end
    // Clock edge with en=1 while reset is held must not capture.
    apply_edge(1'b1, 1, '0, '1, '0, '0);
    n_vec++;
    if (y !== exp_y() || sel_chg !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_blocks_edge y=%h sel_chg=%0b want y=%h sel_chg=0", y, sel_chg, exp_y());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic         e;
    int           s;
    logic [W-1:0] a, b, cc, d;
    for (int k = 0; k < 200; k++) begin
      e  = ($urandom_range(0, 3) != 0);
      s  = int'($urandom_range(0, 3));
      a  = W'($urandom); b = W'($urandom); cc = W'($urandom); d = W'($urandom);
      apply_edge(e, s, a, b, cc, d);
      n_vec++;
      if (y !== exp_y() || sel_chg !== m_chg) begin
        n_bad++;
        $display("FAIL random k=%0d en=%0b sel=%0d y=%h sel_chg=%0b want y=%h sel_chg=%0b",
                 k, e, s, y, sel_chg, exp_y(), m_chg);
      end
    end
  endtask

`ifdef MUX4TO1_COMB_OUT_EN
  task automatic test_comb_out();
    {c1, c0} = 2'b01;
    for (int k = 0; k < 6; k++) begin
      x1 = ~x1;
      #1;
      n_vec++;
      if (y !== x1) begin
        n_bad++;
        $display("FAIL comb_follow k=%0d y=%h want %h", k, y, x1);
      end
      #9;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive();
    test_sel_change();
    test_enable_hold();
    test_async_reset();
    test_random();
`ifdef MUX4TO1_COMB_OUT_EN
    test_comb_out();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
